path_sequencer: RTL and testbench

PATH_SEQUENCER -- requirements
Module: path_sequencer

---
 rtl/path_sequencer_if.sv | 34 +++
 rtl/path_sequencer.sv | 178 +++++++++++++++++
 tb/tb_path_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/path_sequencer_if.sv
// Path-sequencer signal bundle: path loading, traversal control, lookup triple and
// direction handshake. Clock and reset stay outside as plain ports.
interface path_sequencer_if;
    logic       path_clr;
    logic       path_wr;
    logic [7:0] path_wr_data;
    logic [7:0] prev_node_in;
    logic       start;
    logic       abort;
    logic       node_detected;
    logic [3:0] dir_in;
    logic       dir_ack;
    logic [7:0] p_node;
    logic [7:0] c_node;
    logic [7:0] n_node;
    logic [3:0] dir_cmd;
    logic       dir_valid;
    logic       busy;
    logic       done;
    logic       err;
    logic       ovf;

    modport master (
        output path_clr, path_wr, path_wr_data, prev_node_in, start, abort,
               node_detected, dir_in, dir_ack,
        input  p_node, c_node, n_node, dir_cmd, dir_valid, busy, done, err, ovf
    );

    modport slave (
        input  path_clr, path_wr, path_wr_data, prev_node_in, start, abort,
               node_detected, dir_in, dir_ack,
        output p_node, c_node, n_node, dir_cmd, dir_valid, busy, done, err, ovf
    );
endinterface

// File: rtl/path_sequencer.sv
// Walks a buffered node path: per hop, present (prev,cur,next) to the lookup, wait, latch
// the direction and hold dir_valid until dir_ack; all outputs registered, no path pipelining.
module path_sequencer #(
    parameter int DEPTH       = 32,
    parameter int LOOKUP_WAIT = 2
) (
    input  logic            clock,
    input  logic            rst_n,
    path_sequencer_if.slave bus
);
    localparam int IW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LOOKUP_WAIT > 1) ? $clog2(LOOKUP_WAIT) : 1;

    localparam logic [IW-1:0] PTR_ONE   = IW'(1);
    localparam logic [IW-1:0] PTR_TWO   = IW'(2);
    localparam logic [IW-1:0] PTR_FULL  = IW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] WAIT_LAST = CW'((LOOKUP_WAIT > 0) ? LOOKUP_WAIT - 1 : 0);
    localparam logic [3:0]    DIR_LINE  = 4'd2;
    localparam logic [3:0]    DIR_STOP  = 4'd3;

    typedef enum logic [2:0] {IDLE, LOOKUP, ISSUE, TRAVEL, ARRIVE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IW-1:0] idx_q, idx_d, idx_inc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    p_q, p_d, c_q, c_d, n_q, n_d;
    logic [3:0]    dir_cmd_q, dir_cmd_d;
    logic          dir_valid_q, dir_valid_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d, ovf_q, ovf_d;
    logic          buf_we;
    logic [7:0]    buf_mem [DEPTH];

    assign idx_inc = idx_q + PTR_ONE;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        c_d         = c_q;
        n_d         = n_q;
        dir_cmd_d   = dir_cmd_q;
        dir_valid_d = dir_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ovf_d       = ovf_q;
        buf_we      = 1'b0;

        // abort outranks every other event once a traversal is under way
        if (state_q != IDLE && bus.abort) begin
            state_d     = IDLE;
            dir_cmd_d   = DIR_STOP;
            dir_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && wr_ptr_q >= PTR_TWO) begin
                        state_d = LOOKUP;
                        p_d     = bus.prev_node_in;
                        c_d     = buf_mem[0];
                        n_d     = buf_mem[1];
                        idx_d   = PTR_ONE;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = bus.start;
                        if (bus.path_clr) begin
                            wr_ptr_d = '0;
                            ovf_d    = 1'b0;
                        end else if (bus.path_wr) begin
                            if (wr_ptr_q == PTR_FULL) begin
                                ovf_d = 1'b1;
                            end else begin
                                buf_we   = 1'b1;
                                wr_ptr_d = wr_ptr_q + PTR_ONE;
                            end
                        end
                    end
                end
                LOOKUP: begin
                    if (cnt_q == WAIT_LAST) begin
                        dir_cmd_d   = bus.dir_in;
                        dir_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ISSUE: begin
                    if (bus.dir_ack) begin
                        dir_valid_d = 1'b0;
                        state_d     = TRAVEL;
                    end
                end
                TRAVEL: begin
                    if (bus.node_detected) begin
                        p_d   = c_q;
                        c_d   = n_q;
                        idx_d = idx_inc;
                        if (idx_inc == wr_ptr_q) begin
                            state_d     = ARRIVE;
                            dir_cmd_d   = DIR_STOP;
                            dir_valid_d = 1'b1;
                        end else begin
                            n_d     = buf_mem[idx_inc[AW-1:0]];
                            cnt_d   = '0;
                            state_d = LOOKUP;
                        end
                    end
                end
                ARRIVE: begin
                    if (bus.dir_ack) begin
                        dir_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            c_q         <= '0;
            n_q         <= '0;
            dir_cmd_q   <= DIR_LINE;
            dir_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            c_q         <= c_d;
            n_q         <= n_d;
            dir_cmd_q   <= dir_cmd_d;
            dir_valid_q <= dir_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    // path storage is deliberately left out of reset; wr_ptr alone defines valid entries
    always_ff @(posedge clock) begin
        if (rst_n && buf_we) begin
            buf_mem[wr_ptr_q[AW-1:0]] <= bus.path_wr_data;
        end
    end

    assign bus.p_node    = p_q;
    assign bus.c_node    = c_q;
    assign bus.n_node    = n_q;
    assign bus.dir_cmd   = dir_cmd_q;
    assign bus.dir_valid = dir_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_path_sequencer.sv
// Bench for path_sequencer: directed scenarios plus random traffic, every cycle checked
// against a path/leg-level reference model.
module tb_path_sequencer;
    localparam int DEPTH = 32;
    localparam int LW    = 2;
    localparam logic [3:0] D_LINE = 4'd2;
    localparam logic [3:0] D_STOP = 4'd3;
    localparam int M_IDLE = 0, M_WAIT = 1, M_CMD = 2, M_MOVE = 3, M_FINAL = 4;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    path_sequencer_if bus ();

    path_sequencer #(.DEPTH(DEPTH), .LOOKUP_WAIT(LW)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // stand-in for the node-direction table: (0,1,2) maps to LEFT
    function automatic logic [3:0] dir_of(input logic [7:0] p, input logic [7:0] c,
                                          input logic [7:0] n);
        int s;
        s = int'(p) + 2 * int'(c) + 4 * int'(n);
        return 4'(s % 10);
    endfunction

    assign bus.dir_in = dir_of(bus.p_node, bus.c_node, bus.n_node);

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_path[$];
    logic [7:0] m_route[$];
    logic [7:0] m_prev;
    int         m_leg, m_mode, m_timer;
    bit         m_has_route, m_ovf, m_done, m_err, model_live = 0;
    logic [3:0] m_cmd;

    function automatic logic [23:0] exp_triple();
        int nx;
        if (!m_has_route) return 24'd0;
        nx = (m_leg + 1 < m_route.size()) ? m_leg + 1 : m_route.size() - 1;
        return {(m_leg == 0) ? m_prev : m_route[m_leg - 1], m_route[m_leg], m_route[nx]};
    endfunction

    function automatic logic [32:0] exp_outs();
        bit vld;
        vld = (m_mode == M_CMD) || (m_mode == M_FINAL);
        return {exp_triple(), m_cmd, vld, m_mode != M_IDLE, m_done, m_err, m_ovf};
    endfunction

    function automatic logic [32:0] act_outs();
        return {bus.p_node, bus.c_node, bus.n_node, bus.dir_cmd, bus.dir_valid,
                bus.busy, bus.done, bus.err, bus.ovf};
    endfunction

    always @(posedge clock) begin
        logic [23:0] tri_now;
        tri_now = exp_triple();
        if (!rst_n) begin
            model_live = 1;
            m_path.delete();
            m_route.delete();
            m_has_route = 0;
            m_mode = M_IDLE;
            m_leg = 0;
            m_cmd = D_LINE;
            m_ovf = 0; m_done = 0; m_err = 0;
        end else if (model_live) begin
            m_done = 0;
            m_err  = 0;
            if (m_mode != M_IDLE && bus.abort) begin
                m_mode = M_IDLE;
                m_cmd  = D_STOP;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        if (bus.start && m_path.size() >= 2) begin
                            m_route = m_path;
                            m_prev = bus.prev_node_in;
                            m_has_route = 1;
                            m_leg = 0;
                            m_timer = LW;
                            m_mode = M_WAIT;
                        end else begin
                            if (bus.start) m_err = 1;
                            if (bus.path_clr) begin
                                m_path.delete();
                                m_ovf = 0;
                            end else if (bus.path_wr) begin
                                if (m_path.size() == DEPTH) m_ovf = 1;
                                else m_path.push_back(bus.path_wr_data);
                            end
                        end
                    end
                    M_WAIT: begin
                        m_timer--;
                        if (m_timer <= 0) begin
                            m_cmd = dir_of(tri_now[23:16], tri_now[15:8], tri_now[7:0]);
                            m_mode = M_CMD;
                        end
                    end
                    M_CMD: if (bus.dir_ack) m_mode = M_MOVE;
                    M_MOVE: begin
                        if (bus.node_detected) begin
                            m_leg++;
                            if (m_leg == m_route.size() - 1) begin
                                m_mode = M_FINAL;
                                m_cmd = D_STOP;
                            end else begin
                                m_mode = M_WAIT;
                                m_timer = LW;
                            end
                        end
                    end
                    M_FINAL: begin
                        if (bus.dir_ack) begin
                            m_mode = M_IDLE;
                            m_done = 1;
                        end
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (model_live) check("cycle_outputs", 64'(act_outs()), 64'(exp_outs()));
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_node(input logic [7:0] v);
        bus.path_wr = 1; bus.path_wr_data = v;
        @(negedge clock);
        bus.path_wr = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1; @(negedge clock); bus.start = 0;
    endtask

    task automatic pulse_clr();
        bus.path_clr = 1; @(negedge clock); bus.path_clr = 0;
    endtask

    task automatic pulse_ack();
        bus.dir_ack = 1; @(negedge clock); bus.dir_ack = 0;
    endtask

    task automatic pulse_detect();
        bus.node_detected = 1; @(negedge clock); bus.node_detected = 0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (bus.dir_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n == 20) begin
            tests++; fails++;
            $display("FAIL %s: dir_valid=%b after 20 cycles, required 1", name, bus.dir_valid);
        end
    endtask

    task automatic run_to_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            bus.dir_ack = bus.dir_valid;
            bus.node_detected = bus.busy & ~bus.dir_valid;
            @(negedge clock);
            if (bus.done === 1'b1) seen = 1;
        end
        bus.dir_ack = 0;
        bus.node_detected = 0;
        check(name, 64'(seen), 64'd1);
    endtask

    localparam logic [32:0] RESET_OUTS = {24'd0, 4'd2, 5'b00000};

    initial begin
        bus.path_clr = 0; bus.path_wr = 0; bus.path_wr_data = 0; bus.prev_node_in = 0;
        bus.start = 0; bus.abort = 0; bus.node_detected = 0; bus.dir_ack = 0;
        repeat (3) @(negedge clock);
        check("reset_values", 64'(act_outs()), 64'(RESET_OUTS));
        rst_n = 1;

        // basic three-node traversal
        write_node(8'd1); write_node(8'd2); write_node(8'd3);
        bus.prev_node_in = 8'd0;
        pulse_start();
        check("start_triple", 64'({bus.p_node, bus.c_node, bus.n_node, bus.busy}),
              64'({24'h000102, 1'b1}));
        wait_valid("first_cmd");
        check("first_cmd_left", 64'({bus.dir_cmd, bus.dir_valid}), 64'({4'd0, 1'b1}));
        for (int i = 0; i < 10; i++) begin
            bus.node_detected = i[0];
            @(negedge clock);
        end
        bus.node_detected = 0;
        check("issue_hold", 64'({bus.p_node, bus.c_node, bus.n_node, bus.dir_cmd, bus.dir_valid}),
              64'({24'h000102, 4'd0, 1'b1}));
        pulse_ack();
        pulse_detect();
        check("second_triple", 64'({bus.p_node, bus.c_node, bus.n_node}), 64'(24'h010203));
        wait_valid("second_cmd");
        pulse_ack();
        pulse_detect();
        check("arrive_stop", 64'({bus.p_node, bus.c_node, bus.n_node, bus.dir_cmd, bus.dir_valid}),
              64'({24'h020303, 4'd3, 1'b1}));
        pulse_ack();
        check("done_pulse", 64'({bus.done, bus.busy}), 64'({1'b1, 1'b0}));

        // too-short path, then overflow
        pulse_clr();
        write_node(8'd7);
        pulse_start();
        check("short_err", 64'({bus.err, bus.busy}), 64'({1'b1, 1'b0}));
        pulse_clr();
        for (int i = 0; i < 33; i++) write_node(8'($urandom_range(29)));
        check("ovf_set", 64'(bus.ovf), 64'd1);

        // abort mid-travel, then restart the same buffer
        pulse_clr();
        for (int i = 0; i < 4; i++) write_node(8'($urandom_range(29)));
        bus.prev_node_in = 8'd9;
        pulse_start();
        wait_valid("abort_cmd");
        pulse_ack();
        bus.abort = 1; @(negedge clock); bus.abort = 0;
        check("abort_stop", 64'({bus.dir_cmd, bus.dir_valid, bus.busy, bus.done}),
              64'({4'd3, 3'b000}));
        pulse_start();
        run_to_done("restart_done");

        // reset coinciding with abort during LOOKUP
        pulse_start();
        rst_n = 0; bus.abort = 1;
        @(negedge clock);
        check("reset_over_abort", 64'(act_outs()), 64'(RESET_OUTS));
        rst_n = 1; bus.abort = 0;

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bus.path_clr      = ($urandom_range(99) < 3);
            bus.path_wr       = ($urandom_range(99) < 35);
            bus.path_wr_data  = 8'($urandom_range(29));
            bus.prev_node_in  = 8'($urandom_range(29));
            bus.start         = ($urandom_range(99) < 10);
            bus.abort         = ($urandom_range(999) < 8);
            bus.node_detected = ($urandom_range(99) < 25);
            bus.dir_ack       = ($urandom_range(99) < 30);
            rst_n             = ($urandom_range(999) >= 4);
            @(negedge clock);
        end
        rst_n = 1;
        bus.path_clr = 0; bus.path_wr = 0; bus.start = 0; bus.abort = 0;
        bus.node_detected = 0; bus.dir_ack = 0;
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
